// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the front-end stall controller and its helpers.
package pipe_ctrl_pkg;
    localparam int REG_W = 5;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator; $0 never produces a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             i_memread,
    input  logic [REG_W-1:0] i_idex_rt,
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    input  logic             i_uses_rt,
    output logic             o_lu
);
    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_idex_rt == i_ifid_rs);
    assign w_rt_match = i_uses_rt & (i_idex_rt == i_ifid_rt);
    assign o_lu       = i_memread & (i_idex_rt != '0) & (w_rs_match | w_rt_match);
endmodule

// File: rtl/pipe_stall_controller.sv
// Front-end hazard arbiter: MDU occupancy > load-use > branch/jump flush.
// Mealy outputs so a hazard stalls in the cycle it is detected.
module pipe_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic             IDEX_MultiCycle,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             BranchTaken,
    input  logic             Jump,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXBubble,
    output logic             MDUDone,
    output logic [31:0]      StallCycles
);
    localparam bit             MDU_EN   = (MDU_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_EN ? MDU_LATENCY - 2 : 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stall_cnt;
    logic             w_lu;
    logic             w_redirect;
    logic             w_mdu_start;

    load_use_detect u_lu (
        .i_memread (IDEX_MemRead),
        .i_idex_rt (IDEX_Rt),
        .i_ifid_rs (IFID_Rs),
        .i_ifid_rt (IFID_Rt),
        .i_uses_rt (IFID_UsesRt),
        .o_lu      (w_lu)
    );

    assign w_redirect  = BranchTaken | Jump;
    assign w_mdu_start = MDU_EN & IDEX_MultiCycle & (r_state == ST_RUN);

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        MDUDone    = 1'b0;
        if (!Reset) begin
            if (r_state == ST_MDU_WAIT) begin
                if (r_cnt != '0) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXWrite = 1'b0;
                end else begin
                    // Release cycle: EX holds the MDU op, so load-use cannot apply.
                    MDUDone   = 1'b1;
                    IFIDFlush = w_redirect;
                end
            end else if (w_mdu_start) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXWrite = 1'b0;
            end else if (w_lu) begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
            end else begin
                IFIDFlush = w_redirect;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!PCWrite)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            case (r_state)
                ST_RUN: begin
                    if (w_mdu_start) begin
                        r_state <= ST_MDU_WAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                default: begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - CNT_W'(1);
                    else
                        r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign StallCycles = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stall_controller.sv
// Vector-table bench for pipe_stall_controller with a per-cycle scoreboard.
module tb_pipe_stall_controller;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        IDEX_MemRead = 1'b0;
    logic [4:0]  IDEX_Rt = '0;
    logic        IDEX_MultiCycle = 1'b0;
    logic [4:0]  IFID_Rs = '0;
    logic [4:0]  IFID_Rt = '0;
    logic        IFID_UsesRt = 1'b0;
    logic        BranchTaken = 1'b0;
    logic        Jump = 1'b0;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, MDUDone;
    logic [31:0] StallCycles;

    pipe_stall_controller #(.MDU_LATENCY(4), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .IDEX_MultiCycle(IDEX_MultiCycle),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .BranchTaken(BranchTaken), .Jump(Jump),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXWrite(IDEXWrite), .IDEXBubble(IDEXBubble), .MDUDone(MDUDone),
        .StallCycles(StallCycles)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       rst, memrd, multi, usesrt, br, jmp;
        logic [4:0] idex_rt, rs, rt;
        // expected: pcw, ifidw, flush, idexw, bubble, done
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_stall = 0;

    localparam logic [5:0] DEF  = 6'b110100;
    localparam logic [5:0] LU   = 6'b000110;
    localparam logic [5:0] MDU  = 6'b000000;
    localparam logic [5:0] FL   = 6'b111100;
    localparam logic [5:0] DONE = 6'b110101;
    localparam logic [5:0] DNFL = 6'b111101;

    function automatic void add(string n, logic rst, logic memrd, logic [4:0] irt,
                                logic multi, logic [4:0] rs, logic [4:0] rt,
                                logic usesrt, logic br, logic jmp, logic [5:0] exp);
        vec_t v;
        v.name = n; v.rst = rst; v.memrd = memrd; v.idex_rt = irt; v.multi = multi;
        v.rs = rs; v.rt = rt; v.usesrt = usesrt; v.br = br; v.jmp = jmp; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        @(posedge Clk); #1;
        Reset = v.rst; IDEX_MemRead = v.memrd; IDEX_Rt = v.idex_rt;
        IDEX_MultiCycle = v.multi; IFID_Rs = v.rs; IFID_Rt = v.rt;
        IFID_UsesRt = v.usesrt; BranchTaken = v.br; Jump = v.jmp;
        sb.push_back(v);
        @(negedge Clk);
        e = sb.pop_front();
        check({e.name, ".outs"},
              {26'd0, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, MDUDone},
              {26'd0, e.exp});
        check({e.name, ".stall"}, StallCycles, exp_stall);
        if (e.rst) exp_stall = 0;
        else if (!e.exp[5]) exp_stall = exp_stall + 1;
    endtask

    initial begin
        int  stalls;
        bit  done;

        add("rst0", 1,0,0,0,0,0,0,0,0, DEF);
        add("rst1", 1,0,0,0,0,0,0,0,0, DEF);
        for (int i = 0; i < 5; i++) add("idle", 0,0,0,0,0,0,0,0,0, DEF);
        add("lu_rs",     0,1,8,0,8,0,0,0,0, LU);
        add("after_lu",  0,0,0,0,0,0,0,0,0, DEF);
        add("lu_r0",     0,1,0,0,0,0,1,0,0, DEF);
        add("lu_rt",     0,1,9,0,3,9,1,0,0, LU);
        add("lu_rt_nou", 0,1,9,0,3,9,0,0,0, DEF);
        add("lu_nomatch",0,1,9,0,3,4,1,0,0, DEF);
        add("br",        0,0,0,0,0,0,0,1,0, FL);
        add("jmp",       0,0,0,0,0,0,0,0,1, FL);
        add("lu_br",     0,1,7,0,7,0,0,1,0, LU);
        add("idle",      0,0,0,0,0,0,0,0,0, DEF);
        for (int i = 0; i < 3; i++) add("mdu_stall", 0,0,0,1,0,0,0,0,0, MDU);
        add("mdu_done_lu", 0,1,8,1,8,0,0,0,0, DONE);
        add("idle",      0,0,0,0,0,0,0,0,0, DEF);
        for (int i = 0; i < 3; i++) add("mdu_br_stall", 0,0,0,1,0,0,0,1,0, MDU);
        add("mdu_br_done", 0,0,0,1,0,0,0,1,0, DNFL);
        add("idle",      0,0,0,0,0,0,0,0,0, DEF);
        add("mdu_a",     0,0,0,1,0,0,0,0,0, MDU);
        add("mdu_w1",    0,0,0,1,0,0,0,0,0, MDU);
        add("mdu_rst",   1,0,0,1,0,0,0,0,0, DEF);
        add("post_rst",  0,0,0,0,0,0,0,0,0, DEF);
        for (int i = 0; i < 3; i++) add("mdu2_stall", 0,0,0,1,0,0,0,0,0, MDU);
        add("mdu2_done", 0,0,0,1,0,0,0,0,0, DONE);
        add("idle",      0,0,0,0,0,0,0,0,0, DEF);

        foreach (vecs[i]) apply(vecs[i]);

        // Hold a mult/div until release, with a bounded wait on MDUDone.
        stalls = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge Clk); #1;
            IDEX_MultiCycle = 1'b1;
            @(negedge Clk);
            if (!PCWrite) stalls++;
            if (MDUDone) done = 1;
        end
        check("mdu_wait_done", {31'd0, done}, 32'd1);
        check("mdu_wait_stalls", stalls, 32'd3);
        exp_stall = exp_stall + 3;
        begin
            vec_t v;
            v.name = "final_idle"; v.rst = 0; v.memrd = 0; v.idex_rt = 0; v.multi = 0;
            v.rs = 0; v.rt = 0; v.usesrt = 0; v.br = 0; v.jmp = 0; v.exp = DEF;
            apply(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
